decode_8b10b: RTL

- Receive-side counterpart of the 8b/10b line encoder.
- Accepts parallel 10-bit code groups from the deserializer and decodes them to bytes.
- Tracks running disparity (RD) and flags invalid code groups and disparity violations.
- Runs a word-lock state machine that requests a one-bit slip from the deserializer until alignment is found. Sits between the fibre deserializer and the byte-level framing logic.

---
 rtl/decode_8b10b.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/decode_8b10b.sv
// decode_8b10b: 10b code group to byte decoder with running-disparity checking and word-lock/slip control
module decode_8b10b #(
  parameter int GOOD_TO_LOCK  = 4,
  parameter int BAD_TO_UNLOCK = 3,
  parameter int SLIP_HOLDOFF  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] d_in,
  input  logic       in_valid,
  output logic [7:0] d_out,
  output logic       out_valid,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd_out,
  output logic       locked,
  output logic       slip
);
  typedef enum logic [1:0] {HUNT, HOLDOFF, LOCKED} state_t;
  localparam logic [3:0] G_MAX = 4'(GOOD_TO_LOCK - 1);
  localparam logic [3:0] B_MAX = 4'(BAD_TO_UNLOCK - 1);
  localparam logic [7:0] H_MAX = 8'(SLIP_HOLDOFF - 1);
  state_t state, state_nx;
  logic [3:0] good_cnt, good_nx, bad_cnt, bad_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [5:0] s6;
  logic [3:0] s4;
  logic [4:0] dec5;
  logic [2:0] dec3;
  logic v6, v4, p6, n6, p4, n4, rd6, rd4, de6, de4, ce, de, bad, slip_nx;
  assign s6 = d_in[5:0];
  assign s4 = d_in[9:6];
  always_comb begin
    dec5 = '0;
    v6 = 1'b1;
    case (s6)
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110:            dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              v6 = 1'b0;
    endcase
  end
  always_comb begin
    dec3 = '0;
    v4 = 1'b1;
    case (s4)
      4'b1011, 4'b0100:                   dec3 = 3'd0;
      4'b1001:                            dec3 = 3'd1;
      4'b0101:                            dec3 = 3'd2;
      4'b1100, 4'b0011:                   dec3 = 3'd3;
      4'b1101, 4'b0010:                   dec3 = 3'd4;
      4'b1010:                            dec3 = 3'd5;
      4'b0110:                            dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
      default:                            v4 = 1'b0;
    endcase
  end
  // The 4b sub-block is judged against the RD left behind by the 6b sub-block
  always_comb begin
    p6 = $countones(s6) > 3;
    n6 = $countones(s6) < 3;
    p4 = $countones(s4) > 2;
    n4 = $countones(s4) < 2;
    rd6 = p6 ? 1'b1 : n6 ? 1'b0 : rd_out;
    rd4 = p4 ? 1'b1 : n4 ? 1'b0 : rd6;
    de6 = v6 & ((p6 & rd_out) | (n6 & ~rd_out) | (s6 == 6'b111000 & rd_out) | (s6 == 6'b000111 & ~rd_out));
    de4 = v4 & ((p4 & rd6) | (n4 & ~rd6) | (s4 == 4'b1100 & rd6) | (s4 == 4'b0011 & ~rd6));
    ce = ~v6 | ~v4;
    de = de6 | de4;
    bad = ce | de;
  end
  always_comb begin
    state_nx = state;
    good_nx = good_cnt;
    bad_nx = bad_cnt;
    hold_nx = hold_cnt;
    slip_nx = 1'b0;
    if (in_valid)
      case (state)
        HUNT:
          if (bad) begin
            good_nx = '0;
            hold_nx = '0;
            slip_nx = 1'b1;
            state_nx = HOLDOFF;
          end else if (good_cnt >= G_MAX) begin
            good_nx = '0;
            bad_nx = '0;
            state_nx = LOCKED;
          end else good_nx = good_cnt + 4'd1;
        HOLDOFF:
          if (hold_cnt >= H_MAX) begin
            hold_nx = '0;
            good_nx = '0;
            state_nx = HUNT;
          end else hold_nx = hold_cnt + 8'd1;
        LOCKED:
          if (!bad) bad_nx = '0;
          else if (bad_cnt >= B_MAX) begin
            bad_nx = '0;
            good_nx = '0;
            state_nx = HUNT;
          end else bad_nx = bad_cnt + 4'd1;
        default: state_nx = HUNT;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      good_cnt <= '0;
      bad_cnt <= '0;
      hold_cnt <= '0;
      d_out <= '0;
      out_valid <= 1'b0;
      code_err <= 1'b0;
      disp_err <= 1'b0;
      rd_out <= 1'b0;
      locked <= 1'b0;
      slip <= 1'b0;
    end else begin
      out_valid <= in_valid;
      slip <= slip_nx;
      if (in_valid) begin
        d_out <= {dec3, dec5};
        code_err <= ce;
        disp_err <= de;
        rd_out <= rd4;
        state <= state_nx;
        good_cnt <= good_nx;
        bad_cnt <= bad_nx;
        hold_cnt <= hold_nx;
        locked <= state_nx == LOCKED;
      end
    end
endmodule
